ram_s2psbe1c_pl: RTL and testbench

Simple dual-port, single-clock byte-enable RAM with a configurable read pipeline, read-valid signalling and a hardware clear-on-reset engine. Port A is write-only with per-byte enables, port B is read-only. It is the pipelined successor to the basic byte-enable SDP RAM. It sits between a bus-side writer and a datapath reader that needs deterministic memory contents after reset, and a registered read path for timing closure.

---
 rtl/ram_s2psbe1c_pl.sv | 160 ++++++++++++++++
 tb/tb_ram_s2psbe1c_pl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ram_s2psbe1c_pl.sv
// ram_s2psbe1c_pl: simple dual-port, single-clock byte-enable RAM.
// Port A writes with per-byte enables, port B reads through a 1..3 stage
// pipeline with a travelling valid bit. An optional clear engine zeroes the
// array after reset and holds ready_o low until it is done.
// Optional feature macro: RAM_S2PSBE_FWD_EN -- when defined, a same-cycle,
// same-address read sees the newly written lanes (write-first per byte);
// when undefined the read returns the old word (read-first) and no
// forwarding mux is built.
module ram_s2psbe1c_pl #(
    parameter int BYTE_WIDTH     = 8,
    parameter int BYTES_IN_WORD  = 4,
    parameter int WORD_COUNT     = 256,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    localparam int WORD_WIDTH    = BYTE_WIDTH * BYTES_IN_WORD,
    localparam int ADDR_WIDTH    = $clog2(WORD_COUNT)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     ready_o,
    input  logic                     we_a_i,
    input  logic [BYTES_IN_WORD-1:0] be_a_i,
    input  logic [ADDR_WIDTH-1:0]    addr_a_i,
    input  logic [WORD_WIDTH-1:0]    data_a_i,
    input  logic                     re_b_i,
    input  logic [ADDR_WIDTH-1:0]    addr_b_i,
    output logic [WORD_WIDTH-1:0]    data_b_o,
    output logic                     valid_b_o
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                    state_r;
    state_t                    state_next_s;
    logic [ADDR_WIDTH-1:0]     clr_cnt_r;
    logic                      ready_r;

    logic [WORD_WIDTH-1:0]     mem_r [WORD_COUNT];

    logic                      wr_in_range_s;
    logic                      rd_in_range_s;
    logic                      wr_en_s;
    logic                      rd_en_s;
    logic [WORD_WIDTH-1:0]     rd_word_s;

    logic [WORD_WIDTH-1:0]     data_pipe_r [READ_LATENCY];
    logic [READ_LATENCY-1:0]   valid_pipe_r;

    // Address range qualification; only non-power-of-two depths can miss.
    assign wr_in_range_s = (32'(addr_a_i) < WORD_COUNT);
    assign rd_in_range_s = (32'(addr_b_i) < WORD_COUNT);

    // User requests are only honoured once the clear engine has finished.
    assign wr_en_s = we_a_i & ready_r & wr_in_range_s & ~rst_i;
    assign rd_en_s = re_b_i & ready_r;

    // Controller next state: leave CLEAR after the last address is zeroed.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_cnt_r == ADDR_WIDTH'(WORD_COUNT - 1)) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_RUN;
        endcase
    end

    // Controller state and registered ready flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if (CLEAR_ON_RESET != 0) begin
                state_r <= ST_CLEAR;
                ready_r <= 1'b0;
            end else begin
                state_r <= ST_RUN;
                ready_r <= 1'b1;
            end
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == ST_RUN);
        end
    end

    // Clear address counter; stops at the last word instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clr_cnt_r <= '0;
        end else if ((state_r == ST_CLEAR) && (state_next_s == ST_CLEAR)) begin
            clr_cnt_r <= clr_cnt_r + ADDR_WIDTH'(1);
        end else begin
            clr_cnt_r <= clr_cnt_r;
        end
    end

    // Array write port: clear engine zeroes words, otherwise byte-lane writes.
    always_ff @(posedge clk_i) begin
        if ((state_r == ST_CLEAR) && !rst_i) begin
            mem_r[clr_cnt_r] <= '0;
        end else if (wr_en_s) begin
            for (int i = 0; i < BYTES_IN_WORD; i++) begin
                if (be_a_i[i]) begin
                    mem_r[addr_a_i][BYTE_WIDTH*i +: BYTE_WIDTH] <= data_a_i[BYTE_WIDTH*i +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read word selection: zero for out-of-range, optional per-lane forwarding.
    always_comb begin
        rd_word_s = '0;
        if (rd_in_range_s) begin
`ifdef RAM_S2PSBE_FWD_EN
            for (int i = 0; i < BYTES_IN_WORD; i++) begin
                rd_word_s[BYTE_WIDTH*i +: BYTE_WIDTH] =
                    (wr_en_s && (addr_a_i == addr_b_i) && be_a_i[i]) ?
                    data_a_i[BYTE_WIDTH*i +: BYTE_WIDTH] :
                    mem_r[addr_b_i][BYTE_WIDTH*i +: BYTE_WIDTH];
            end
`else
            rd_word_s = mem_r[addr_b_i];
`endif
        end else begin
            rd_word_s = '0;
        end
    end

    // Read pipeline: valid travels every cycle, data loads only behind a valid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_pipe_r <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_pipe_r[i] <= '0;
            end
        end else begin
            valid_pipe_r[0] <= rd_en_s;
            if (rd_en_s) begin
                data_pipe_r[0] <= rd_word_s;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_pipe_r[i] <= valid_pipe_r[i-1];
                if (valid_pipe_r[i-1]) begin
                    data_pipe_r[i] <= data_pipe_r[i-1];
                end
            end
        end
    end

    assign ready_o   = ready_r;
    assign data_b_o  = data_pipe_r[READ_LATENCY-1];
    assign valid_b_o = valid_pipe_r[READ_LATENCY-1];

endmodule

// File: tb/tb_ram_s2psbe1c_pl.sv
// Scoreboard bench for ram_s2psbe1c_pl (WORD_COUNT=200, READ_LATENCY=3).
// Stimulus pushes the expected word and sample cycle for each read; a
// separate monitor pops and compares whenever valid_b_o is seen.
module tb_ram_s2psbe1c_pl;

    localparam int WC = 200;
    localparam int RL = 3;
    localparam int AW = $clog2(WC);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ready;
    logic          we = 1'b0;
    logic [3:0]    be = 4'b0000;
    logic [AW-1:0] addr_a = '0;
    logic [31:0]   data_a = 32'h0;
    logic          re = 1'b0;
    logic [AW-1:0] addr_b = '0;
    logic [31:0]   data_b;
    logic          valid_b;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ram_s2psbe1c_pl #(
        .BYTE_WIDTH(8), .BYTES_IN_WORD(4), .WORD_COUNT(WC),
        .READ_LATENCY(RL), .CLEAR_ON_RESET(1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .ready_o(ready),
        .we_a_i(we), .be_a_i(be), .addr_a_i(addr_a), .data_a_i(data_a),
        .re_b_i(re), .addr_b_i(addr_b), .data_b_o(data_b), .valid_b_o(valid_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every valid output must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && valid_b) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got data %h at cycle %0d, required no valid", data_b, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (data_b !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL read_data: got %h at cycle %0d, required %h at cycle %0d",
                             data_b, cyc, e.data, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; a read pushes its expected word and sample cycle.
    task automatic drive(input logic w, input logic [3:0] b, input logic [AW-1:0] aw,
                         input logic [31:0] dw, input logic r, input logic [AW-1:0] ar,
                         input logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        we = w; be = b; addr_a = aw; data_a = dw;
        re = r; addr_b = ar;
        if (r) begin
            e.data = exp;
            e.cyc  = cyc + RL;
            q.push_back(e);
        end
    endtask

    task automatic wr(input logic [3:0] b, input logic [AW-1:0] a, input logic [31:0] d);
        drive(1'b1, b, a, d, 1'b0, '0, 32'h0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp);
        drive(1'b0, 4'b0000, '0, 32'h0, 1'b1, a, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'b0000, '0, 32'h0, 1'b0, '0, 32'h0);
    endtask

    // Count rising edges from reset release until ready_o is seen high.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (ready) break;
        end
        chk(name, 32'(n), 32'(WC));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values.
        #3;
        chk("reset_ready", 32'(ready), 32'h0);
        chk("reset_valid", 32'(valid_b), 32'h0);
        chk("reset_data", data_b, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_ready("clear_cycles");

        // Whole array reads back as zero after the clear.
        for (int a = 0; a < WC; a++) rd(AW'(a), 32'h0);

        // Byte-lane writes.
        wr(4'b1111, 8'd5, 32'hAABBCCDD);
        wr(4'b0101, 8'd5, 32'h11223344);
        rd(8'd5, 32'hAA22CC44);

        // Collision at address 9.
        wr(4'b1111, 8'd9, 32'h01020304);
`ifdef RAM_S2PSBE_FWD_EN
        drive(1'b1, 4'b0011, 8'd9, 32'hFFFFFFFF, 1'b1, 8'd9, 32'h0102FFFF);
`else
        drive(1'b1, 4'b0011, 8'd9, 32'hFFFFFFFF, 1'b1, 8'd9, 32'h01020304);
`endif
        rd(8'd9, 32'h0102FFFF);

        // Pipeline: fill 0..7, a no-op be=0 write, then back-to-back reads.
        for (int a = 0; a < 8; a++) wr(4'b1111, AW'(a), 32'hC0DE0000 | 32'(a));
        wr(4'b0000, 8'd7, 32'hFFFFFFFF);
        for (int a = 0; a < 8; a++) rd(AW'(a), 32'hC0DE0000 | 32'(a));
        idle(6);
        chk("hold_data", data_b, 32'hC0DE0007);
        chk("hold_valid", 32'(valid_b), 32'h0);

        // Reset with reads in flight.
        rd(8'd1, 32'hC0DE0001);
        rd(8'd2, 32'hC0DE0002);
        rd(8'd3, 32'hC0DE0003);
        @(negedge clk);
        re = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midop_valid", 32'(valid_b), 32'h0);
        chk("midop_data", data_b, 32'h0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;

        // Requests during clear are ignored; reset halfway restarts the clear.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            we = 1'b1; be = 4'b1111; addr_a = 8'd3; data_a = 32'hDEADBEEF;
            re = 1'b1; addr_b = 8'd3;
        end
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        chk("clear_ready_low", 32'(ready), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ready("reclear_cycles");
        rd(8'd3, 32'h0);
        rd(8'd5, 32'h0);

        // Out-of-range write dropped, out-of-range read returns zero.
        wr(4'b1111, 8'd210, 32'h12345678);
        rd(8'd210, 32'h0);
        rd(8'd192, 32'h0);
        rd(8'd10, 32'h0);
        rd(8'd82, 32'h0);
        idle(8);
        chk("scoreboard_empty", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
